// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's view of the shared data-RAM port.
//
// Signals
//   req    : access request, held with we/addr/wdata stable until gnt
//   we     : 1 = write, 0 = read
//   addr   : word address (AW bits)
//   wdata  : write data (DW bits)
//   gnt    : access issued this cycle (combinational)
//   rvalid : read data valid this cycle (one cycle after a read grant)
//   rdata  : read data, zero whenever rvalid is low
//
// Modports
//   master : the requester (core, debug loader, DMA)
//   slave  : the arbiter
interface ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single data-RAM port between the core (m0) and a
// secondary requester such as a debug loader or DMA (m1).  At most one
// access is issued per cycle; synchronous read data is steered back to the
// port that issued the read.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   key       : synchronous active-high reset
//   m0, m1    : requester ports (ram_arbiter_if.slave), m0 has priority
//   ram_en    : RAM write enable
//   ram_addr  : RAM address
//   ram_wdata : RAM write data
//   ram_rdata : RAM read data, valid one cycle after the address
//
// Configuration
//   ARB_STARVE_GUARD_EN : when defined, m1 is promoted over m0 after
//                         MAX_WAIT consecutive denied cycles.  Otherwise m0
//                         has strict priority and m1 may starve.
//
// The interface instances connected to m0/m1 must use the same AW/DW.
module ram_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          key,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  logic gnt0;
  logic gnt1;
  logic promote;
  logic tag_valid;
  logic tag_port;
  logic rvalid0;
  logic rvalid1;

  // Grant selection.  Nothing is granted while reset is held, so no access
  // can leak out during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!key) begin
      if (m1.req && (!m0.req || promote)) begin
        gnt1 = 1'b1;
      end else if (m0.req) begin
        gnt0 = 1'b1;
      end
    end
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // RAM-side mux: the granted port owns the bus, otherwise it is idle at 0.
  always_comb begin
    ram_en    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_en    = m0.we;
      ram_addr  = m0.addr;
      ram_wdata = m0.wdata;
    end else if (gnt1) begin
      ram_en    = m1.we;
      ram_addr  = m1.addr;
      ram_wdata = m1.wdata;
    end
  end

  // Read tag {valid, port}: remembers which port owns the data the RAM
  // returns next cycle.  Reloaded every cycle, so reads fully pipeline.
  always_ff @(posedge clk) begin
    if (key) begin
      tag_valid <= 1'b0;
      tag_port  <= 1'b0;
    end else begin
      tag_valid <= (gnt0 && !m0.we) || (gnt1 && !m1.we);
      tag_port  <= gnt1;
    end
  end

  // Gating with key drops the response of a read whose data would arrive
  // in a reset cycle.
  assign rvalid0 = tag_valid && !tag_port && !key;
  assign rvalid1 = tag_valid &&  tag_port && !key;

  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rvalid0 ? ram_rdata : '0;
  assign m1.rdata  = rvalid1 ? ram_rdata : '0;

`ifdef ARB_STARVE_GUARD_EN
  localparam int            CW         = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  // Counts consecutive cycles m1 is denied; saturates at the limit.  The
  // promotion flag is the saturated state, so it clears together with the
  // counter as soon as m1 is granted or withdraws its request.
  always_ff @(posedge clk) begin
    if (key) begin
      wait_cnt <= '0;
    end else if (!m1.req || gnt1) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign promote = (wait_cnt == WAIT_LIMIT);
`else
  // Strict m0 priority; MAX_WAIT is only meaningful with the guard, and
  // this compare is constant false.
  assign promote = (MAX_WAIT < 0);
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a
// behavioural synchronous RAM.  RAM word i is preloaded with 0x1000_0000+i.
// Inputs change on the falling edge; outputs are checked 1 ns later, so each
// check sees the cycle that ends at the next rising edge.
module tb_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

`ifdef ARB_STARVE_GUARD_EN
  localparam int PROMO_CYCLE = 4;
`else
  localparam int PROMO_CYCLE = -1;
`endif

  logic          clk = 1'b0;
  logic          key;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] mem [0:255];

  int vectors     = 0;
  int miscompares = 0;

  ram_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
  ram_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();

  ram_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (4)
  ) dut (
    .clk       (clk),
    .key       (key),
    .m0        (m0_bus.slave),
    .m1        (m1_bus.slave),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write on the edge, read data one cycle after address.
  always @(posedge clk) begin
    if (ram_en) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s miscompared", tag);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic r0, input logic w0,
                               input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic r1, input logic w1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(negedge clk);
    key          = rst;
    m0_bus.req   = r0;
    m0_bus.we    = w0;
    m0_bus.addr  = a0;
    m0_bus.wdata = d0;
    m1_bus.req   = r1;
    m1_bus.we    = w1;
    m1_bus.addr  = a1;
    m1_bus.wdata = d1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    key = 1'b1;
    m0_bus.req = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0;
    m1_bus.req = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0;

    // Reset held 3 cycles with both ports requesting
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0001, 32'h0, 1'b1, 1'b1, 16'h0002, 32'h55);
      checkOutput("rst_m0_gnt",    m0_bus.gnt,    0);
      checkOutput("rst_m1_gnt",    m1_bus.gnt,    0);
      checkOutput("rst_ram_en",    ram_en,        0);
      checkOutput("rst_ram_addr",  ram_addr,      0);
      checkOutput("rst_ram_wdata", ram_wdata,     0);
      checkOutput("rst_m0_rvalid", m0_bus.rvalid, 0);
      checkOutput("rst_m1_rvalid", m1_bus.rvalid, 0);
    end

    // First cycle after reset, idle
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("post_rst_m0_rvalid", m0_bus.rvalid, 0);
    checkOutput("post_rst_m1_rvalid", m1_bus.rvalid, 0);
    checkOutput("post_rst_m0_rdata",  m0_bus.rdata,  0);
    checkOutput("post_rst_m1_rdata",  m1_bus.rdata,  0);
    checkOutput("idle_ram_en",        ram_en,        0);

    // Port 0 write 0xDEADBEEF to 0x0010, then read it back
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("wr_m0_gnt",    m0_bus.gnt, 1);
    checkOutput("wr_m1_gnt",    m1_bus.gnt, 0);
    checkOutput("wr_ram_en",    ram_en,     1);
    checkOutput("wr_ram_addr",  ram_addr,   32'h0010);
    checkOutput("wr_ram_wdata", ram_wdata,  32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("rd_m0_gnt",    m0_bus.gnt,    1);
    checkOutput("rd_ram_en",    ram_en,        0);
    checkOutput("rd_ram_addr",  ram_addr,      32'h0010);
    checkOutput("rd_ram_wdata", ram_wdata,     0);
    checkOutput("wr_no_rvalid", m0_bus.rvalid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("rd_m0_rvalid", m0_bus.rvalid, 1);
    checkOutput("rd_m0_rdata",  m0_bus.rdata,  32'hDEADBEEF);
    checkOutput("rd_m1_rvalid", m1_bus.rvalid, 0);
    checkOutput("rd_m1_rdata",  m1_bus.rdata,  0);

    // Conflict: both read, m0 wins, m1 served next cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0004, 32'h0, 1'b1, 1'b0, 16'h0008, 32'h0);
    checkOutput("cf_m0_gnt",   m0_bus.gnt, 1);
    checkOutput("cf_m1_gnt",   m1_bus.gnt, 0);
    checkOutput("cf_ram_addr", ram_addr,   32'h0004);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0008, 32'h0);
    checkOutput("cf2_m1_gnt",    m1_bus.gnt,    1);
    checkOutput("cf2_m0_gnt",    m0_bus.gnt,    0);
    checkOutput("cf2_ram_addr",  ram_addr,      32'h0008);
    checkOutput("cf2_m0_rvalid", m0_bus.rvalid, 1);
    checkOutput("cf2_m0_rdata",  m0_bus.rdata,  32'h1000_0004);
    checkOutput("cf2_m1_rvalid", m1_bus.rvalid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("cf3_m1_rvalid", m1_bus.rvalid, 1);
    checkOutput("cf3_m1_rdata",  m1_bus.rdata,  32'h1000_0008);
    checkOutput("cf3_m0_rvalid", m0_bus.rvalid, 0);
    checkOutput("cf3_m0_rdata",  m0_bus.rdata,  0);

    // Pipelined m0 reads of 0x0000, 0x0001, 0x0002
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("pl0_m0_gnt",    m0_bus.gnt,    1);
    checkOutput("pl0_m0_rvalid", m0_bus.rvalid, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0001, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("pl1_m0_rvalid", m0_bus.rvalid, 1);
    checkOutput("pl1_m0_rdata",  m0_bus.rdata,  32'h1000_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0002, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("pl2_m0_rvalid", m0_bus.rvalid, 1);
    checkOutput("pl2_m0_rdata",  m0_bus.rdata,  32'h1000_0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("pl3_m0_rvalid", m0_bus.rvalid, 1);
    checkOutput("pl3_m0_rdata",  m0_bus.rdata,  32'h1000_0002);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("pl4_m0_rvalid", m0_bus.rvalid, 0);

    // Reset arriving the cycle after an m1 read grant
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0008, 32'h0);
    checkOutput("rr_m1_gnt", m1_bus.gnt, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("rr1_m1_rvalid", m1_bus.rvalid, 0);
    checkOutput("rr1_m1_rdata",  m1_bus.rdata,  0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("rr2_m1_rvalid", m1_bus.rvalid, 0);
    checkOutput("rr2_m1_rdata",  m1_bus.rdata,  0);

    // Starvation: m0 requests continuously, m1 from cycle 0
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0001, 32'h0, 1'b1, 1'b0, 16'h0002, 32'h0);
      checkOutput($sformatf("sv%0d_m1_gnt", c), m1_bus.gnt, (c == PROMO_CYCLE) ? 1 : 0);
      checkOutput($sformatf("sv%0d_m0_gnt", c), m0_bus.gnt, (c == PROMO_CYCLE) ? 0 : 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("sv_end_m1_rvalid", m1_bus.rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single data-RAM port of `Memory` between the rv32i core (port 0) and a secondary requester (port 1: debug/loader or DMA). Inserted between the core's `mem_w`/`alu_res`/`write_data`/`read_data` signals and the RAM side of `Memory`. It issues at most one access per cycle and routes synchronous read data back to the requester that issued the read.

## Interface
- `AW`, 16, address width (matches `addr_ram`)
- `DW`, 32, data width
- `MAX_WAIT`, 8, consecutive denied cycles before port 1 is promoted (only with `ARB_STARVE_GUARD_EN`)

- `clk  in  1  clock; all state updates on the rising edge`
- `key  in  1  reset, synchronous, active-high`
- `m0_req / m1_req  in  1  access request; held high with addr/we/wdata stable until gnt`
- `m0_we / m1_we  in  1  1 = write, 0 = read`
- `m0_addr / m1_addr  in  AW  word address`
- `m0_wdata / m1_wdata  in  DW  write data`
- `m0_gnt / m1_gnt  out  1  combinational; access issued this cycle`
- `m0_rvalid / m1_rvalid  out  1  registered; read data valid this cycle`
- `m0_rdata / m1_rdata  out  DW  read data; 0 when the matching rvalid is 0`
- `ram_en  out  1  RAM write enable (`en`)`
- `ram_addr  out  AW  RAM address (`addr_ram`)`
- `ram_wdata  out  DW  RAM write data (`data`)`
- `ram_rdata  in  DW  RAM read data (`out_ram`), valid one cycle after the address is presented`

## Operation
- Conflict (both req high): port 0 wins, unless the promotion flag is set (see Configuration), in which case port 1 wins.
- Single requester: granted in the same cycle, zero wait.
- Granted port drives `ram_addr`, `ram_wdata`, and `ram_en = we`. With no grant: `ram_addr = 0`, `ram_wdata = 0`, `ram_en = 0`.
- Exactly one of `m0_gnt`/`m1_gnt` is high in any cycle, or neither.
- Read tracking: a 2-bit registered tag `{valid, port}` is loaded on every granted read and cleared otherwise. Next cycle, `mX_rvalid = 1` for the tagged port and `mX_rdata = ram_rdata`; the other port sees `rvalid = 0` and `rdata = 0`.
- A denied requester keeps `req` asserted. The arbiter does not queue; a request dropped before grant is lost silently.
- Writes produce no response beyond `gnt`.

## Timing
- Cycle N: `req` high and granted, so `gnt` is high in cycle N and the RAM is addressed in cycle N. A write commits at the edge closing cycle N. For a read, `rvalid` and `rdata` appear in cycle N+1.
- Back-to-back: one access per cycle, and reads are fully pipelined. Read in N plus a different port's read in N+1 gives rvalid for the first port in N+1 and for the second port in N+2.
- A write in N followed by a read of the same address in N+1 returns the new data in N+2.
- Reset (`key` = 1 at a rising edge) clears the read tag, wait counter and promotion flag.
- While `key` is high: all `gnt` = 0, `ram_en` = 0, `ram_addr` = 0, `ram_wdata` = 0. In the cycle after reset, all `rvalid` = 0 and all `rdata` = 0.
- Reset arriving in the cycle after a read grant suppresses that read's `rvalid`.

## Configuration
- Macro `ARB_STARVE_GUARD_EN` defined: a counter of width clog2(`MAX_WAIT`+1) tracks starvation of port 1.
  - It increments each cycle `m1_req` = 1 and `m1_gnt` = 0.
  - It clears when `m1_gnt` = 1 or `m1_req` = 0.
  - At `MAX_WAIT` it saturates and raises the promotion flag. Port 1 then wins the next conflict, and the flag clears with the counter on that grant.
- Macro undefined: strict port 0 priority. Port 1 may starve indefinitely. Counter and flag are not instantiated.

## Test plan
- Reset: hold `key` = 1 for 3 cycles with both req high, so all `gnt`, `ram_en`, `rvalid` = 0 and `ram_addr` = 0.
- Port 0 write then read: write 0xDEADBEEF to 0x0010 in N and read 0x0010 in N+1. `m0_gnt` is high in both cycles, `m0_rvalid` is high in N+2 with `m0_rdata` = 0xDEADBEEF, and `m1_rvalid` stays 0.
- Conflict: both ports read in the same cycle (m0 addr 0x0004, m1 addr 0x0008). `m0_gnt` = 1 and `m1_gnt` = 0. Next cycle, `m1_gnt` = 1 (m0 has dropped req). Data returns on the correct port in order.
- Starvation (`ARB_STARVE_GUARD_EN`, `MAX_WAIT` = 4): m0 requests continuously and m1 requests from cycle 0. `m1_gnt` = 1 in cycle 4 and `m0_gnt` = 0 in cycle 4; m0 regains priority in cycle 5. Without the macro, `m1_gnt` never asserts.
- Reset mid-read: m1 read granted in N and `key` = 1 in N+1, so `m1_rvalid` = 0 in N+1 and N+2.
- Pipelined reads: m0 reads 0x0000, 0x0001, 0x0002 in consecutive cycles, giving three consecutive `m0_rvalid` pulses with matching data.
